// File: rtl/gcd_driver.sv
// Handshaking driver that hands operand pairs to a GCD unit, with a response timeout.
// Optional result checker enabled by defining GCD_DRIVER_CHECK_EN.
module gcd_driver #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_x,
  input  logic [3:0] req_y,
  output logic       gcd_start,
  output logic [3:0] gcd_x,
  output logic [3:0] gcd_y,
  input  logic [3:0] gcd_result,
  input  logic       gcd_done,
  output logic       rsp_valid,
  output logic [3:0] rsp_data,
  output logic       rsp_timeout,
  input  logic       rsp_ready,
  output logic       busy,
  output logic       check_err
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [7:0] timer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= 8'd0;
      req_ready   <= 1'b0;
      gcd_start   <= 1'b0;
      gcd_x       <= 4'd0;
      gcd_y       <= 4'd0;
      rsp_valid   <= 1'b0;
      rsp_data    <= 4'd0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      gcd_start <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          if (req_valid && req_ready) begin
            gcd_x     <= req_x;
            gcd_y     <= req_y;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_x != 4'd0 && req_y != 4'd0) begin
              gcd_start <= 1'b1;
              state     <= START;
            end else begin
              // gcd(0,n) = n, so the unit is bypassed entirely
              rsp_data    <= req_x | req_y;
              rsp_timeout <= 1'b0;
              rsp_valid   <= 1'b1;
              state       <= RESP;
            end
          end
        end
        START: begin
          timer <= 8'd0;
          state <= WAIT;
        end
        WAIT: begin
          if (gcd_done) begin
            rsp_data    <= gcd_result;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (timer == TIMER_LAST) begin
            rsp_data    <= 4'd0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GCD_DRIVER_CHECK_EN
  logic bad_result;

  always_comb begin
    bad_result = 1'b0;
    if (gcd_result == 4'd0)
      bad_result = 1'b1;
    else if ((gcd_x % gcd_result) != 4'd0 || (gcd_y % gcd_result) != 4'd0)
      bad_result = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      check_err <= 1'b0;
    else if (state == WAIT && gcd_done && bad_result)
      check_err <= 1'b1;
  end
`else
  assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_driver.sv
// Directed self-checking bench for gcd_driver; the GCD unit is emulated by driving gcd_done/gcd_result.
module tb_gcd_driver;
  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready;
  logic [3:0] req_x, req_y;
  logic       gcd_start;
  logic [3:0] gcd_x, gcd_y;
  logic [3:0] gcd_result;
  logic       gcd_done;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       rsp_timeout;
  logic       rsp_ready;
  logic       busy;
  logic       check_err;

  int checks = 0;
  int errors = 0;

  gcd_driver #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .gcd_start(gcd_start), .gcd_x(gcd_x), .gcd_y(gcd_y),
    .gcd_result(gcd_result), .gcd_done(gcd_done),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .rsp_ready(rsp_ready), .busy(busy), .check_err(check_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end else begin
      $display("ok   %s: %0d", tag, actual);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a nonzero request, then return res after 'lat' cycles counted from the start cycle
  task automatic run_op(input logic [3:0] x, input logic [3:0] y, input logic [3:0] res, input int lat);
    req_valid = 1'b1; req_x = x; req_y = y;
    tick();
    req_valid = 1'b0;
    repeat (lat - 1) tick();
    gcd_done = 1'b1; gcd_result = res;
    tick();
    gcd_done = 1'b0; gcd_result = 4'd0;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_x = 4'd0; req_y = 4'd0;
    gcd_result = 4'd0; gcd_done = 1'b0; rsp_ready = 1'b1;
    #1;
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    tick();
    check("idle_req_ready", req_ready, 1);

    // Done in IDLE must be ignored
    gcd_done = 1'b1; gcd_result = 4'd7;
    tick();
    gcd_done = 1'b0;
    check("idle_done_ignored", rsp_valid, 0);

    // Basic 14,6 -> 2, done 4 cycles after start
    req_valid = 1'b1; req_x = 4'd14; req_y = 4'd6;
    tick();
    req_valid = 1'b0;
    check("basic_start", gcd_start, 1);
    check("basic_gcd_x", gcd_x, 14);
    check("basic_gcd_y", gcd_y, 6);
    check("basic_busy", busy, 1);
    check("basic_req_ready", req_ready, 0);
    tick();
    check("basic_start_pulse", gcd_start, 0);
    tick(); tick(); tick();
    check("basic_x_stable", gcd_x, 14);
    check("basic_no_rsp_yet", rsp_valid, 0);
    gcd_done = 1'b1; gcd_result = 4'd2;
    tick();
    gcd_done = 1'b0;
    check("basic_rsp_valid", rsp_valid, 1);
    check("basic_rsp_data", rsp_data, 2);
    check("basic_rsp_timeout", rsp_timeout, 0);
    check("basic_y_stable", gcd_y, 6);
    tick();
    check("basic_handshake", rsp_valid, 0);
    check("basic_idle_ready", req_ready, 1);
    check("basic_idle_busy", busy, 0);

    // Zero operands bypass the unit
    req_valid = 1'b1; req_x = 4'd0; req_y = 4'd9;
    tick();
    req_valid = 1'b0;
    check("zero09_valid", rsp_valid, 1);
    check("zero09_data", rsp_data, 9);
    check("zero09_no_start", gcd_start, 0);
    tick();
    check("zero09_idle", req_ready, 1);
    req_valid = 1'b1; req_x = 4'd0; req_y = 4'd0;
    tick();
    req_valid = 1'b0;
    check("zero00_valid", rsp_valid, 1);
    check("zero00_data", rsp_data, 0);
    check("zero00_no_start", gcd_start, 0);
    tick();

    // Timeout: 8,12 with no done
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_x = 4'd8; req_y = 4'd12;
    tick();
    req_valid = 1'b0;
    tick();
    repeat (63) tick();
    check("to_not_early", rsp_valid, 0);
    tick();
    check("to_valid", rsp_valid, 1);
    check("to_flag", rsp_timeout, 1);
    check("to_data", rsp_data, 0);
    gcd_done = 1'b1; gcd_result = 4'd5;
    tick();
    gcd_done = 1'b0;
    check("to_stray_data", rsp_data, 0);
    check("to_stray_flag", rsp_timeout, 1);
    rsp_ready = 1'b1;
    tick();
    check("to_idle", rsp_valid, 0);
    gcd_done = 1'b1; gcd_result = 4'd5;
    tick();
    gcd_done = 1'b0;
    check("to_stray_idle", rsp_valid, 0);

    // Backpressure with result 3
    rsp_ready = 1'b0;
    run_op(4'd9, 4'd12, 4'd3, 3);
    req_valid = 1'b1; req_x = 4'd5; req_y = 4'd5;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 3);
      check("bp_req_ready", req_ready, 0);
      check("bp_busy", busy, 1);
      tick();
    end
    check("bp_no_new_start", gcd_start, 0);
    check("bp_x_held", gcd_x, 9);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("bp_released", rsp_valid, 0);
    check("bp_idle_busy", busy, 0);
    check("bp_idle_ready", req_ready, 1);

    // Asynchronous reset in WAIT
    req_valid = 1'b1; req_x = 4'd14; req_y = 4'd6;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_gcd_x", gcd_x, 0);
    check("rst_gcd_y", gcd_y, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_start", gcd_start, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("rst_no_rsp", rsp_valid, 0);
    check("rst_ready_back", req_ready, 1);
    run_op(4'd9, 4'd6, 4'd3, 2);
    check("post_rst_valid", rsp_valid, 1);
    check("post_rst_data", rsp_data, 3);
    tick();

`ifdef GCD_DRIVER_CHECK_EN
    run_op(4'd14, 4'd6, 4'd2, 2);
    tick();
    check("chk_good", check_err, 0);
    run_op(4'd14, 4'd6, 4'd4, 2);
    check("chk_bad", check_err, 1);
    tick();
    run_op(4'd14, 4'd6, 4'd2, 2);
    tick();
    check("chk_sticky", check_err, 1);
`else
    check("chk_tied_off", check_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
